// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; result returns 1 clock (EXEC_CYCLES) or MUL_CYCLES after accept.
// Backpressure: no new request is accepted until the owner takes its response; reqN_ready never depends on rsp*_ready.
module alu_share_arbiter #(
   parameter int MUL_CYCLES  = 2,
   parameter int EXEC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [6:0]  req0_opcode,
   input  logic [6:0]  req0_funct7,
   input  logic [2:0]  req0_funct3,
   input  logic [11:0] req0_imm,
   input  logic [7:0]  req0_pc,
   input  logic [31:0] req0_rs1,
   input  logic [31:0] req0_rs2,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [6:0]  req1_opcode,
   input  logic [6:0]  req1_funct7,
   input  logic [2:0]  req1_funct3,
   input  logic [11:0] req1_imm,
   input  logic [7:0]  req1_pc,
   input  logic [31:0] req1_rs1,
   input  logic [31:0] req1_rs2,
   output logic [6:0]  alu_opcode,
   output logic [6:0]  alu_funct7,
   output logic [2:0]  alu_funct3,
   output logic [11:0] alu_imm,
   output logic [7:0]  alu_pc,
   output logic [31:0] alu_rs1_val,
   output logic [31:0] alu_rs2_val,
   input  logic [31:0] alu_rd_val,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_data,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_data
);

   localparam int MUL_N  = (MUL_CYCLES  < 1) ? 1 : MUL_CYCLES;
   localparam int EXEC_N = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
   localparam int MAX_N  = (MUL_N > EXEC_N) ? MUL_N : EXEC_N;
   localparam int CW     = $clog2(MAX_N + 1);
   localparam logic [CW-1:0] MUL_LD  = CW'(MUL_N);
   localparam logic [CW-1:0] EXEC_LD = CW'(EXEC_N);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef struct packed {
      logic [6:0]  opcode;
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [11:0] imm;
      logic [7:0]  pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } op_t;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state;
   logic          rr_last;
   logic          owner;
   logic [CW-1:0] cnt;
   op_t           alu_q;

   op_t  req0_op;
   op_t  req1_op;
   op_t  sel_op;
   logic grant_vld;
   logic grant_id;
   logic sel_is_mul;
   logic owner_rdy;

   assign req0_op = {req0_opcode, req0_funct7, req0_funct3, req0_imm, req0_pc, req0_rs1, req0_rs2};
   assign req1_op = {req1_opcode, req1_funct7, req1_funct3, req1_imm, req1_pc, req1_rs1, req1_rs2};

   // Ready is masked during reset so a held request is never seen as accepted.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (state == IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~rr_last;
         end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
         end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
         end
      end
   end

   assign req0_ready = grant_vld && !grant_id;
   assign req1_ready = grant_vld &&  grant_id;

   assign sel_op     = grant_id ? req1_op : req0_op;
   assign sel_is_mul = (sel_op.opcode == 7'b0110011) && (sel_op.funct3 == 3'b000) &&
                       (sel_op.funct7 == 7'b0000001);
   assign owner_rdy  = owner ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_last    <= 1'b1;
         owner      <= 1'b0;
         cnt        <= '0;
         alu_q      <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= 32'd0;
         rsp1_data  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  alu_q <= sel_op;
                  owner <= grant_id;
                  cnt   <= sel_is_mul ? MUL_LD : EXEC_LD;
                  state <= EXEC;
               end
            end
            EXEC: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  // Per-requester data registers double as the result store.
                  if (owner) begin
                     rsp1_data  <= alu_rd_val;
                     rsp1_valid <= 1'b1;
                  end else begin
                     rsp0_data  <= alu_rd_val;
                     rsp0_valid <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               if (owner_rdy) begin
                  rr_last    <= owner;
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign alu_opcode  = alu_q.opcode;
   assign alu_funct7  = alu_q.funct7;
   assign alu_funct3  = alu_q.funct3;
   assign alu_imm     = alu_q.imm;
   assign alu_pc      = alu_q.pc;
   assign alu_rs1_val = alu_q.rs1;
   assign alu_rs2_val = alu_q.rs2;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table of single-requester ops plus contention, backpressure and reset sequences.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [6:0]  req0_opcode, req0_funct7, req1_opcode, req1_funct7;
   logic [2:0]  req0_funct3, req1_funct3;
   logic [11:0] req0_imm, req1_imm;
   logic [7:0]  req0_pc, req1_pc;
   logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
   logic [6:0]  alu_opcode, alu_funct7;
   logic [2:0]  alu_funct3;
   logic [11:0] alu_imm;
   logic [7:0]  alu_pc;
   logic [31:0] alu_rs1_val, alu_rs2_val, alu_rd_val;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_data, rsp1_data;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_data [2];

   always #5 clk = ~clk;

   alu_share_arbiter #(.MUL_CYCLES(2), .EXEC_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_funct7(req0_funct7), .req0_funct3(req0_funct3), .req0_imm(req0_imm),
      .req0_pc(req0_pc), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_funct7(req1_funct7), .req1_funct3(req1_funct3), .req1_imm(req1_imm),
      .req1_pc(req1_pc), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
      .alu_opcode(alu_opcode), .alu_funct7(alu_funct7), .alu_funct3(alu_funct3),
      .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rs1_val(alu_rs1_val),
      .alu_rs2_val(alu_rs2_val), .alu_rd_val(alu_rd_val),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data)
   );

   // Reference ALU: ADD/SUB/MUL, ADDI, LUI; anything else returns 0.
   always_comb begin
      alu_rd_val = 32'd0;
      if (alu_opcode == 7'b0110011 && alu_funct3 == 3'b000) begin
         if (alu_funct7 == 7'b0000000)      alu_rd_val = alu_rs1_val + alu_rs2_val;
         else if (alu_funct7 == 7'b0100000) alu_rd_val = alu_rs1_val - alu_rs2_val;
         else if (alu_funct7 == 7'b0000001) alu_rd_val = alu_rs1_val * alu_rs2_val;
      end else if (alu_opcode == 7'b0010011 && alu_funct3 == 3'b000) begin
         alu_rd_val = alu_rs1_val + {{20{alu_imm[11]}}, alu_imm};
      end else if (alu_opcode == 7'b0110111) begin
         alu_rd_val = {8'd0, alu_imm, 12'd0};
      end
   end

   typedef struct {
      bit          id;
      logic [6:0]  op;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [7:0]  pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   function automatic vec_t mk(input bit id, input logic [6:0] op, input logic [6:0] f7,
                               input logic [2:0] f3, input logic [11:0] imm, input logic [7:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] exp, input int lat);
      vec_t v;
      v.id = id; v.op = op; v.f7 = f7; v.f3 = f3; v.imm = imm; v.pc = pc;
      v.rs1 = rs1; v.rs2 = rs2; v.exp = exp; v.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic drive_req(input bit id, input logic vld, input vec_t v);
      if (!id) begin
         req0_valid = vld; req0_opcode = v.op; req0_funct7 = v.f7; req0_funct3 = v.f3;
         req0_imm = v.imm; req0_pc = v.pc; req0_rs1 = v.rs1; req0_rs2 = v.rs2;
      end else begin
         req1_valid = vld; req1_opcode = v.op; req1_funct7 = v.f7; req1_funct3 = v.f3;
         req1_imm = v.imm; req1_pc = v.pc; req1_rs1 = v.rs1; req1_rs2 = v.rs2;
      end
   endtask

   function automatic logic rdy_of(input bit id);
      return id ? req1_ready : req0_ready;
   endfunction

   function automatic logic vld_of(input bit id);
      return id ? rsp1_valid : rsp0_valid;
   endfunction

   function automatic logic [31:0] data_of(input bit id);
      return id ? rsp1_data : rsp0_data;
   endfunction

   // Entered and left at posedge+1 with the DUT idle; rsp ready is held high.
   task automatic run_vec(input vec_t v);
      int   waited;
      int   lat;
      bit   got;
      bit   unstable;
      logic [100:0] exp_alu;
      exp_alu = {v.op, v.f7, v.f3, v.imm, v.pc, v.rs1, v.rs2};
      drive_req(v.id, 1'b1, v);
      @(negedge clk);
      waited = 0;
      while (!rdy_of(v.id) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("grant_wait", waited, 0);
      check("other_ready", {31'd0, rdy_of(!v.id)}, 0);
      @(posedge clk); #1;
      check("ready_one_cycle", {31'd0, rdy_of(v.id)}, 0);
      drive_req(v.id, 1'b0, v);
      lat = 0; got = 0; unstable = 0;
      while (!got && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if ({alu_opcode, alu_funct7, alu_funct3, alu_imm, alu_pc, alu_rs1_val, alu_rs2_val} !== exp_alu)
            unstable = 1;
         got = vld_of(v.id);
      end
      check("latency", lat, v.lat);
      check("rsp_data", data_of(v.id), v.exp);
      check("other_rsp_valid", {31'd0, vld_of(!v.id)}, 0);
      check("other_data_hold", data_of(!v.id), last_data[!v.id]);
      check("alu_stable", {31'd0, unstable}, 0);
      last_data[v.id] = v.exp;
      @(posedge clk); #1;
      check("rsp_valid_drop", {31'd0, vld_of(v.id)}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [8];
      vec_t ca, cb, vb, vs;
      int   w;
      vecs[0] = mk(0, 7'b0110011, 7'b0000000, 3'b000, 12'h000, 8'h10, 32'd5,  32'd7, 32'd12, 1);
      vecs[1] = mk(1, 7'b0110011, 7'b0000001, 3'b000, 12'h000, 8'h20, 32'd6,  32'd7, 32'd42, 2);
      vecs[2] = mk(0, 7'b0110011, 7'b0100000, 3'b000, 12'h123, 8'h14, 32'd20, 32'd5, 32'd15, 1);
      vecs[3] = mk(0, 7'b0110011, 7'b0000001, 3'b001, 12'h000, 8'h18, 32'd9,  32'd9, 32'd0,  1);
      vecs[4] = mk(0, 7'b0110011, 7'b0000001, 3'b000, 12'h000, 8'h1c, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 2);
      vecs[5] = mk(1, 7'b0110111, 7'b0000000, 3'b000, 12'h001, 8'h24, 32'd0, 32'd0, 32'h00001000, 1);
      vecs[6] = mk(1, 7'b0110111, 7'b0000000, 3'b000, 12'h001, 8'h28, 32'd0, 32'd0, 32'h00001000, 1);
      vecs[7] = mk(1, 7'b0110111, 7'b0000000, 3'b000, 12'h001, 8'h2c, 32'd0, 32'd0, 32'h00001000, 1);
      ca = mk(0, 7'b0110011, 7'b0000000, 3'b000, 12'h000, 8'h30, 32'd1,  32'd2,  32'd3,  1);
      cb = mk(1, 7'b0110011, 7'b0000000, 3'b000, 12'h000, 8'h40, 32'd10, 32'd20, 32'd30, 1);
      vb = mk(0, 7'b0010011, 7'b0000000, 3'b000, 12'hFFF, 8'h50, 32'd10, 32'd0,  32'd9,  1);
      vs = mk(0, 7'b0110011, 7'b0100000, 3'b000, 12'h000, 8'h60, 32'd9,  32'd4,  32'd5,  1);
      last_data[0] = 32'd0;
      last_data[1] = 32'd0;

      rst = 1'b1;
      drive_req(0, 1'b0, ca);
      drive_req(1, 1'b0, cb);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_handshakes", {28'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
      check("reset_rsp0_data", rsp0_data, 0);
      check("reset_rsp1_data", rsp1_data, 0);
      check("reset_alu_ops", {alu_opcode, alu_funct7, alu_funct3, alu_imm}, 0);
      check("reset_alu_rs1", alu_rs1_val, 0);
      rst = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 8; k++) run_vec(vecs[k]);

      // Contention: grants must alternate starting with req0.
      drive_req(0, 1'b1, ca);
      drive_req(1, 1'b1, cb);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         w = 0;
         while (!(req0_ready || req1_ready) && w < 20) begin @(negedge clk); w++; end
         check("cont_grant_id", {31'd0, req1_ready}, k % 2);
         check("cont_onehot", {31'd0, req0_ready & req1_ready}, 0);
         w = 0;
         while (!(rsp0_valid || rsp1_valid) && w < 20) begin @(negedge clk); w++; end
         check("cont_rsp_owner", {30'd0, rsp1_valid, rsp0_valid}, (k % 2) ? 2 : 1);
         check("cont_rsp_data", (k % 2) ? rsp1_data : rsp0_data, (k % 2) ? 32'd30 : 32'd3);
      end
      @(posedge clk); #1;
      drive_req(0, 1'b0, ca);
      drive_req(1, 1'b0, cb);

      // Backpressure on rsp0 while req1 waits.
      rsp0_ready = 1'b0;
      drive_req(0, 1'b1, vb);
      @(negedge clk);
      check("bp_req0_ready", {31'd0, req0_ready}, 1);
      @(posedge clk); #1;
      drive_req(0, 1'b0, vb);
      drive_req(1, 1'b1, cb);
      @(negedge clk);
      w = 0;
      while (!rsp0_valid && w < 20) begin
         check("bp_req1_blocked_exec", {31'd0, req1_ready}, 0);
         @(negedge clk);
         w++;
      end
      for (int h = 0; h < 4; h++) begin
         check("bp_hold_valid", {31'd0, rsp0_valid}, 1);
         check("bp_hold_data", rsp0_data, 32'd9);
         check("bp_req1_blocked", {31'd0, req1_ready}, 0);
         if (h < 3) @(negedge clk);
      end
      rsp0_ready = 1'b1;
      @(negedge clk);
      check("bp_rsp0_drop", {31'd0, rsp0_valid}, 0);
      check("bp_req1_granted", {31'd0, req1_ready}, 1);
      @(posedge clk); #1;
      drive_req(1, 1'b0, cb);
      @(negedge clk);
      w = 0;
      while (!rsp1_valid && w < 20) begin @(negedge clk); w++; end
      check("bp_req1_data", rsp1_data, 32'd30);
      check("bp_rsp0_data_kept", rsp0_data, 32'd9);
      @(posedge clk); #1;

      // Reset in the middle of EXEC aborts the SUB.
      drive_req(0, 1'b1, vs);
      @(negedge clk);
      check("rst_seq_accept", {31'd0, req0_ready}, 1);
      @(posedge clk); #1;
      drive_req(0, 1'b0, vs);
      drive_req(1, 1'b1, cb);
      rst = 1'b1;
      #1;
      check("rst_outputs_low", {28'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
      check("rst_alu_cleared", alu_rs1_val, 0);
      @(negedge clk);
      drive_req(1, 1'b0, cb);
      rst = 1'b0;
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         check("rst_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 0);
      end
      @(posedge clk); #1;
      drive_req(0, 1'b1, vs);
      drive_req(1, 1'b1, cb);
      @(negedge clk);
      check("rst_first_grant", {30'd0, req0_ready, req1_ready}, 2);
      @(posedge clk); #1;
      drive_req(0, 1'b0, vs);
      drive_req(1, 1'b0, cb);
      @(negedge clk);
      w = 0;
      while (!rsp0_valid && w < 20) begin @(negedge clk); w++; end
      check("rst_next_data", rsp0_data, 32'd5);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
